// File: rtl/accum_warp_looper_memofs_arbiter.sv
// rtl/accum_warp_looper_memofs_arbiter.sv - shared memory-offset stage arbiter for warp-looper requesters
//
// Purpose:
//   Arbitrates N_REQ warp-looper requesters onto one shared memory-offset
//   stage. Grants are round-robin. With MEMOFS_ARB_BURST_LOCK_EN defined, a
//   requester keeps the grant until its islast item is loaded. A credit
//   counter limits items granted but not yet retired, and a done pulse is
//   raised when a requester's islast item leaves the stage.
//
// Optional feature macro: MEMOFS_ARB_BURST_LOCK_EN
//   defined   -> burst locking (IDLE/LOCKED FSM) active
//   undefined -> pure per-item round-robin, no FSM
//
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req_rdy        per-requester item available
//   o_req_ack        one-hot (or zero) item accepted this cycle, combinational
//   i_req_id         packed per-requester config id (ID_BW bits each)
//   i_req_islast     per-requester last-item-of-burst flag
//   o_mux_rdy        registered item valid toward the shared stage
//   i_mux_ack        shared stage accepts the item
//   o_mux_sel        requester index of the item in the slot
//   o_mux_id         config id of the item in the slot
//   o_mux_islast     islast of the item in the slot
//   i_ret_valid      an item left the stage
//   i_ret_sel        requester index carried with the retired item
//   i_ret_islast     retired item was the last of its burst
//   o_done           one-cycle per-requester burst-retired pulse
//   o_inflight       current credit usage
module accum_warp_looper_memofs_arbiter #(
  parameter int N_REQ        = 4,
  parameter int N_CFG        = 4,
  parameter int MAX_INFLIGHT = 4,
  localparam int ID_BW  = $clog2(N_CFG + 1),
  localparam int REQ_BW = $clog2(N_REQ),
  localparam int CNT_BW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_req_rdy,
  output logic [N_REQ-1:0]       o_req_ack,
  input  logic [N_REQ*ID_BW-1:0] i_req_id,
  input  logic [N_REQ-1:0]       i_req_islast,
  output logic                   o_mux_rdy,
  input  logic                   i_mux_ack,
  output logic [REQ_BW-1:0]      o_mux_sel,
  output logic [ID_BW-1:0]       o_mux_id,
  output logic                   o_mux_islast,
  input  logic                   i_ret_valid,
  input  logic [REQ_BW-1:0]      i_ret_sel,
  input  logic                   i_ret_islast,
  output logic [N_REQ-1:0]       o_done,
  output logic [CNT_BW-1:0]      o_inflight
);

  localparam logic [CNT_BW-1:0] MAX_CNT = CNT_BW'(MAX_INFLIGHT);

  logic              mux_rdy_q,    mux_rdy_d;
  logic [REQ_BW-1:0] mux_sel_q,    mux_sel_d;
  logic [ID_BW-1:0]  mux_id_q,     mux_id_d;
  logic              mux_islast_q, mux_islast_d;
  logic [N_REQ-1:0]  done_q,       done_d;
  logic [CNT_BW-1:0] inflight_q,   inflight_d;
  logic [REQ_BW-1:0] ptr_q,        ptr_d;

  logic              slot_free;
  logic              can_grant;
  logic              load;
  logic              rr_vld;
  logic [REQ_BW-1:0] rr_idx;
  logic              grant_vld;
  logic [REQ_BW-1:0] grant_idx;
  logic [ID_BW-1:0]  req_id [N_REQ];

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_id[k] = i_req_id[k*ID_BW +: ID_BW];
    end
  end

  // First ready requester at or after the pointer; N_REQ is a power of two,
  // so the REQ_BW-wide add wraps on its own.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rr_vld && i_req_rdy[ptr_q + REQ_BW'(i)]) begin
        rr_vld = 1'b1;
        rr_idx = ptr_q + REQ_BW'(i);
      end
    end
  end

`ifdef MEMOFS_ARB_BURST_LOCK_EN
  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [REQ_BW-1:0] owner_q, owner_d;

  // While locked only the owner can win, even if it has nothing to send.
  always_comb begin
    if (state_q == ST_LOCKED) begin
      grant_vld = i_req_rdy[owner_q];
      grant_idx = owner_q;
    end else begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end
  end
`else
  assign grant_vld = rr_vld;
  assign grant_idx = rr_idx;
`endif

  always_comb begin
    slot_free = !mux_rdy_q || i_mux_ack;
    // A retirement in the same cycle frees the credit this grant needs.
    can_grant = (inflight_q < MAX_CNT) || i_ret_valid;
    load      = !i_rst && slot_free && can_grant && grant_vld;
    o_req_ack = load ? (N_REQ'(1) << grant_idx) : '0;

    mux_rdy_d    = mux_rdy_q;
    mux_sel_d    = mux_sel_q;
    mux_id_d     = mux_id_q;
    mux_islast_d = mux_islast_q;
    if (load) begin
      mux_rdy_d    = 1'b1;
      mux_sel_d    = grant_idx;
      mux_id_d     = req_id[grant_idx];
      mux_islast_d = i_req_islast[grant_idx];
    end else if (i_mux_ack) begin
      mux_rdy_d = 1'b0;
    end

    inflight_d = inflight_q;
    if (load && !i_ret_valid) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!load && i_ret_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - 1'b1;
    end

    done_d = (i_ret_valid && i_ret_islast) ? (N_REQ'(1) << i_ret_sel) : '0;

    ptr_d = ptr_q;
`ifdef MEMOFS_ARB_BURST_LOCK_EN
    state_d = state_q;
    owner_d = owner_q;
    // The pointer moves only on the first grant of a burst.
    if (load) begin
      if (state_q == ST_IDLE) begin
        ptr_d = grant_idx + 1'b1;
        if (!i_req_islast[grant_idx]) begin
          state_d = ST_LOCKED;
          owner_d = grant_idx;
        end
      end else if (i_req_islast[grant_idx]) begin
        state_d = ST_IDLE;
      end
    end
`else
    if (load) begin
      ptr_d = grant_idx + 1'b1;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mux_rdy_q    <= 1'b0;
      mux_sel_q    <= '0;
      mux_id_q     <= '0;
      mux_islast_q <= 1'b0;
      done_q       <= '0;
      inflight_q   <= '0;
      ptr_q        <= '0;
`ifdef MEMOFS_ARB_BURST_LOCK_EN
      state_q      <= ST_IDLE;
      owner_q      <= '0;
`endif
    end else begin
      mux_rdy_q    <= mux_rdy_d;
      mux_sel_q    <= mux_sel_d;
      mux_id_q     <= mux_id_d;
      mux_islast_q <= mux_islast_d;
      done_q       <= done_d;
      inflight_q   <= inflight_d;
      ptr_q        <= ptr_d;
`ifdef MEMOFS_ARB_BURST_LOCK_EN
      state_q      <= state_d;
      owner_q      <= owner_d;
`endif
    end
  end

  // A return with no credit in use means the downstream lost track of the pipe.
  ret_underflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_ret_valid && (inflight_q == '0)));

  assign o_mux_rdy    = mux_rdy_q;
  assign o_mux_sel    = mux_sel_q;
  assign o_mux_id     = mux_id_q;
  assign o_mux_islast = mux_islast_q;
  assign o_done       = done_q;
  assign o_inflight   = inflight_q;

endmodule

// File: tb/tb_accum_warp_looper_memofs_arbiter.sv
// tb/tb_accum_warp_looper_memofs_arbiter.sv - scoreboard bench for the memory-offset stage arbiter
module tb_accum_warp_looper_memofs_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_BW = 3;
  localparam int REQ_BW = 2;
  localparam int CNT_BW = 3;

  typedef struct packed {
    logic [REQ_BW-1:0] sel;
    logic [ID_BW-1:0]  id;
    logic              islast;
  } item_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_rdy;
  logic [N_REQ-1:0]       o_req_ack;
  logic [N_REQ*ID_BW-1:0] i_req_id;
  logic [ID_BW-1:0]       req_id [N_REQ];
  logic [N_REQ-1:0]       req_islast;
  logic                   o_mux_rdy;
  logic                   mux_ack;
  logic [REQ_BW-1:0]      o_mux_sel;
  logic [ID_BW-1:0]       o_mux_id;
  logic                   o_mux_islast;
  logic                   ret_valid;
  logic [REQ_BW-1:0]      ret_sel;
  logic                   ret_islast;
  logic [N_REQ-1:0]       o_done;
  logic [CNT_BW-1:0]      o_inflight;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  bit    mon_en = 1'b0;

  assign i_req_id = {req_id[3], req_id[2], req_id[1], req_id[0]};

  always #5 clk = ~clk;

  accum_warp_looper_memofs_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_rdy    (req_rdy),
    .o_req_ack    (o_req_ack),
    .i_req_id     (i_req_id),
    .i_req_islast (req_islast),
    .o_mux_rdy    (o_mux_rdy),
    .i_mux_ack    (mux_ack),
    .o_mux_sel    (o_mux_sel),
    .o_mux_id     (o_mux_id),
    .o_mux_islast (o_mux_islast),
    .i_ret_valid  (ret_valid),
    .i_ret_sel    (ret_sel),
    .i_ret_islast (ret_islast),
    .o_done       (o_done),
    .o_inflight   (o_inflight)
  );

  // Every item the shared stage accepts must match the head of the scoreboard.
  always @(negedge clk) begin
    item_t got;
    item_t want;
    if (mon_en && !rst && o_mux_rdy && mux_ack) begin
      got = {o_mux_sel, o_mux_id, o_mux_islast};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: accepted item %h, none expected", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL scoreboard_item: got sel=%0d id=%0d last=%0d, want sel=%0d id=%0d last=%0d",
                   got.sel, got.id, got.islast, want.sel, want.id, want.islast);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic item_t mk(int sel, int id, bit last);
    return {REQ_BW'(sel), ID_BW'(id), last};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_rdy    = '0;
    req_islast = '0;
    mux_ack    = 1'b0;
    ret_valid  = 1'b0;
    ret_sel    = '0;
    ret_islast = 1'b0;
    for (int k = 0; k < N_REQ; k++) req_id[k] = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    exp_q.delete();
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    mon_en = 1'b0;
    rst = 1'b1;
    next();
    next();
    rst = 1'b0;
    req_rdy = 4'b0100;
    req_islast = 4'b0100;
    req_id[2] = 3'd5;
    next();
    @(negedge clk);
    n_vec++;
    if (o_mux_rdy !== 1'b1 || o_mux_sel !== 2'd2 || o_inflight !== 3'd1) begin
      n_err++;
      $display("FAIL pre_reset_load: rdy=%0d sel=%0d inflight=%0d, want 1 2 1", o_mux_rdy, o_mux_sel, o_inflight);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({o_mux_rdy, o_mux_sel, o_mux_id, o_mux_islast, o_done, o_inflight, o_req_ack} !== '0) begin
      n_err++;
      $display("FAIL async_reset: rdy=%0d sel=%0d id=%0d last=%0d done=%b infl=%0d ack=%b, want all 0",
               o_mux_rdy, o_mux_sel, o_mux_id, o_mux_islast, o_done, o_inflight, o_req_ack);
    end
    clear_inputs();
    next();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (o_mux_rdy !== 1'b0 || o_inflight !== 3'd0 || o_req_ack !== 4'd0 || o_done !== 4'd0) begin
        n_err++;
        $display("FAIL idle_after_reset: rdy=%0d infl=%0d ack=%b done=%b, want 0", o_mux_rdy, o_inflight, o_req_ack, o_done);
      end
      next();
    end
    mon_en = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] want_ack;
    logic [3:0] want_done;
    do_reset();
    req_islast = 4'b1111;
    for (int k = 0; k < N_REQ; k++) req_id[k] = ID_BW'(k + 1);
    mux_ack = 1'b1;
    ret_islast = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_rdy   = (c < 5) ? 4'hF : 4'h0;
      ret_valid = (c >= 1 && c <= 5);
      ret_sel   = REQ_BW'((c + 3) % 4);
      want_ack  = (c < 5) ? 4'(1 << (c % 4)) : 4'h0;
      want_done = (c >= 2 && c <= 6) ? 4'(1 << ((c - 2) % 4)) : 4'h0;
      if (c < 5) exp_q.push_back(mk(c % 4, c % 4 + 1, 1'b1));
      @(negedge clk);
      n_vec++;
      if (o_req_ack !== want_ack) begin
        n_err++;
        $display("FAIL rr_ack cycle %0d: got %b want %b", c, o_req_ack, want_ack);
      end
      n_vec++;
      if (o_done !== want_done) begin
        n_err++;
        $display("FAIL rr_done cycle %0d: got %b want %b", c, o_done, want_done);
      end
      next();
    end
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_inflight !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_drain: inflight=%0d pending=%0d, want 0 0", o_inflight, exp_q.size());
    end
    next();
  endtask

  task automatic test_burst_lock();
    int         seq[$];
    int         n0;
    logic [3:0] want_ack;
`ifdef MEMOFS_ARB_BURST_LOCK_EN
    seq = '{0, 0, 0, 1};
`else
    seq = '{0, 1, 0, 1, 0};
`endif
    do_reset();
    req_id[0] = 3'd3;
    req_id[1] = 3'd6;
    mux_ack = 1'b1;
    n0 = 0;
    for (int c = 0; c < seq.size(); c++) begin
      req_rdy[0]    = (n0 < 3);
      req_islast[0] = (n0 == 2);
      req_rdy[1]    = 1'b1;
      req_islast[1] = 1'b1;
      ret_valid     = (c > 0);
      ret_sel       = '0;
      ret_islast    = 1'b0;
      want_ack      = 4'(1 << seq[c]);
      if (seq[c] == 0) begin
        exp_q.push_back(mk(0, 3, n0 == 2));
        n0++;
      end else begin
        exp_q.push_back(mk(1, 6, 1'b1));
      end
      @(negedge clk);
      n_vec++;
      if (o_req_ack !== want_ack) begin
        n_err++;
        $display("FAIL burst_ack cycle %0d: got %b want %b", c, o_req_ack, want_ack);
      end
      next();
    end
    req_rdy = '0;
    ret_valid = 1'b1;
    next();
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_inflight !== 3'd0 || o_mux_rdy !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL burst_drain: inflight=%0d rdy=%0d pending=%0d, want 0 0 0", o_inflight, o_mux_rdy, exp_q.size());
    end
    next();
  endtask

  task automatic test_credit_limit();
    do_reset();
    req_rdy = 4'b0100;
    req_islast = 4'b0100;
    req_id[2] = 3'd2;
    mux_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back(mk(2, 2, 1'b1));
      @(negedge clk);
      n_vec++;
      if (o_req_ack !== 4'b0100) begin
        n_err++;
        $display("FAIL credit_grant %0d: got %b want 0100", c, o_req_ack);
      end
      next();
    end
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0000 || o_mux_rdy !== 1'b1 || o_inflight !== 3'd4) begin
      n_err++;
      $display("FAIL credit_full: ack=%b rdy=%0d infl=%0d, want 0000 1 4", o_req_ack, o_mux_rdy, o_inflight);
    end
    next();
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0000 || o_mux_rdy !== 1'b0 || o_inflight !== 3'd4) begin
      n_err++;
      $display("FAIL credit_stall: ack=%b rdy=%0d infl=%0d, want 0000 0 4", o_req_ack, o_mux_rdy, o_inflight);
    end
    next();
    ret_valid = 1'b1;
    ret_sel = 2'd2;
    ret_islast = 1'b0;
    exp_q.push_back(mk(2, 2, 1'b1));
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0100) begin
      n_err++;
      $display("FAIL credit_ret_grant: got %b want 0100", o_req_ack);
    end
    next();
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_inflight !== 3'd4 || o_mux_rdy !== 1'b1 || o_req_ack !== 4'b0000) begin
      n_err++;
      $display("FAIL credit_after_ret: infl=%0d rdy=%0d ack=%b, want 4 1 0000", o_inflight, o_mux_rdy, o_req_ack);
    end
    next();
    req_rdy = '0;
    ret_valid = 1'b1;
    for (int c = 0; c < 4; c++) next();
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_inflight !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL credit_drain: inflight=%0d pending=%0d, want 0 0", o_inflight, exp_q.size());
    end
    next();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_id[1] = 3'd4;
    req_id[3] = 3'd7;
    req_rdy = 4'b1010;
    req_islast = 4'b1010;
    mux_ack = 1'b0;
    exp_q.push_back(mk(1, 4, 1'b1));
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_first_ack: got %b want 0010", o_req_ack);
    end
    next();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (o_req_ack !== 4'b0000 || o_mux_rdy !== 1'b1 || o_mux_sel !== 2'd1 ||
          o_mux_id !== 3'd4 || o_mux_islast !== 1'b1 || o_inflight !== 3'd1) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: ack=%b rdy=%0d sel=%0d id=%0d last=%0d infl=%0d, want 0000 1 1 4 1 1",
                 c, o_req_ack, o_mux_rdy, o_mux_sel, o_mux_id, o_mux_islast, o_inflight);
      end
      next();
    end
    mux_ack = 1'b1;
    exp_q.push_back(mk(3, 7, 1'b1));
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b1000) begin
      n_err++;
      $display("FAIL bp_release_ack: got %b want 1000", o_req_ack);
    end
    next();
    req_rdy = '0;
    next();
    ret_valid = 1'b1;
    next();
    next();
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_inflight !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: inflight=%0d pending=%0d, want 0 0", o_inflight, exp_q.size());
    end
    next();
  endtask

  task automatic test_done_pulse();
    do_reset();
    mux_ack = 1'b1;
    req_rdy = 4'b0100;
    req_islast = 4'b0100;
    req_id[2] = 3'd1;
    exp_q.push_back(mk(2, 1, 1'b1));
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0100) begin
      n_err++;
      $display("FAIL done_first_ack: got %b want 0100", o_req_ack);
    end
    next();
    req_rdy = 4'b0001;
    req_islast = 4'b0001;
    req_id[0] = 3'd2;
    ret_valid = 1'b1;
    ret_sel = 2'd2;
    ret_islast = 1'b1;
    exp_q.push_back(mk(0, 2, 1'b1));
    @(negedge clk);
    n_vec++;
    if (o_req_ack !== 4'b0001 || o_done !== 4'b0000) begin
      n_err++;
      $display("FAIL done_ret_grant: ack=%b done=%b, want 0001 0000", o_req_ack, o_done);
    end
    next();
    req_rdy = '0;
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_done !== 4'b0100 || o_inflight !== 3'd1) begin
      n_err++;
      $display("FAIL done_pulse: done=%b infl=%0d, want 0100 1", o_done, o_inflight);
    end
    next();
    ret_valid = 1'b1;
    ret_sel = 2'd0;
    ret_islast = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_done !== 4'b0000) begin
      n_err++;
      $display("FAIL done_one_cycle: done=%b want 0000", o_done);
    end
    next();
    ret_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_done !== 4'b0000 || o_inflight !== 3'd0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL done_drain: done=%b infl=%0d pending=%0d, want 0000 0 0", o_done, o_inflight, exp_q.size());
    end
    next();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_credit_limit();
    test_backpressure();
    test_done_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
